spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
- SPI target front end, directly upstream of the subperipheral selector.
- Oversamples the external SPI pins in the system clock domain.
- Deserialises the first byte of each transaction as the subperipheral address and later bytes as write data.
- Serialises selector read data back onto CIPO. SPI mode 0, MSB first, chip select active low.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth on spi_select_in, spi_clock_in and spi_data_in (minimum 2)
IDLE_CIPO, 1'b0, level driven on spi_data_out during the address byte and when deselected

Ports:
clock_in  input  1  system clock; ≥8× SPI clock frequency
reset_in  input  1  synchronous reset, active high
spi_select_in  input  1  SPI chip select, active low, asynchronous to clock_in
spi_clock_in  input  1  SPI SCLK (CPOL=0), asynchronous
spi_data_in  input  1  COPI, asynchronous
spi_data_out  output  1  CIPO
address_out  output  8  address byte of current transaction
address_out_valid  output  1  high from address capture until deselect
data_out  output  8  last received data byte
data_out_valid  output  1  one-cycle pulse per received data byte
data_in  input  8  read byte from selector
data_in_valid  input  1  qualifies data_in

Behaviour:
Reset:
- When reset_in is high at a clock_in edge: all outputs 0 except spi_data_out=IDLE_CIPO.
- Also cleared: state=IDLE, bit counter=0, shift registers=0, synchronisers loaded with idle levels (select=1, sclk=0, copi=0).

Synchronisation and edges:
- All three pins pass through SYNC_STAGES flops.
- Rising and falling SCLK edges are detected by comparing the last synchroniser stage with one extra delay flop.
- Edge detection latency from pin: SYNC_STAGES+1 cycles.
- Edges are acted on only while synchronised select is 0.

State machine (IDLE, ADDRESS, DATA):
- IDLE -> ADDRESS: synchronised select falls. Bit counter=0.
- ADDRESS:
  - Each rising SCLK shifts COPI into the receive register, MSB first.
  - On the 8th rising edge, the next cycle: address_out = received byte, address_out_valid=1, bit counter=0, go to DATA.
- DATA:
  - Each rising SCLK shifts in one bit.
  - On the 8th: data_out = byte, data_out_valid=1 for exactly one cycle, counter wraps to 0.
  - address_out is held constant throughout DATA.
- Any state -> IDLE: synchronised select rises (has priority over a coincident SCLK edge).
  - address_out_valid drops the next cycle.
  - Partial byte discarded, no data_out_valid pulse.
  - address_out and data_out keep their last values.

Transmit path:
- Transmit register load: 2 cycles after each byte completion (address or data), i.e. one cycle after the valid/pulse is visible to the selector.
  - Loaded value is data_in if data_in_valid=1, otherwise 8'h00.
- spi_data_out MSB:
  - Appears at that load cycle, ahead of the next rising SCLK.
  - Each subsequent falling SCLK (excluding the falling edge of the byte's 8th bit) shifts the next bit out.
- Behaviour during transactions:
  - During ADDRESS, spi_data_out = IDLE_CIPO.
  - Byte n+1 on CIPO returns data captured after byte n completes. The first read byte follows the address byte.
- Deselect:
  - spi_data_out returns to IDLE_CIPO the cycle after select is seen high.

Boundaries:
- Select low with zero clocks then high: no outputs change.
- Back-to-back transactions with select high for ≥ SYNC_STAGES+1 cycles must be decoded independently.
- SCLK edges closer than 4 clock_in cycles are out of specification; behaviour is undefined.
- A data byte completing on the same cycle select rises is discarded.

Test Plan:
- Write: select low; send 0xA0, 0x12, 0x34 at clock_in/8.
  - address_out=0xA0 with valid after 8th bit.
  - data_out pulses 0x12 then 0x34, each exactly one cycle.
  - valid drops within SYNC_STAGES+2 cycles of select high.
- Read: send 0xB5 then two dummy bytes; data_in=0x5A, 0xC3 with valid=1 → CIPO sampled on rising SCLK reads 0x5A then 0xC3; CIPO is IDLE_CIPO during the address byte.
- data_in_valid=0 during read → CIPO returns 0x00.
- Abort: send 0xA0 then 5 bits of data, deselect.
  - No data_out_valid pulse.
  - Next transaction 0xB5, 0x77 decodes correctly.
- Reset asserted mid-DATA byte → next cycle all outputs at reset values; a fresh transaction after release decodes normally.
- Two transactions separated by SYNC_STAGES+1 idle cycles (0xA0/0x01 then 0xB5/0x02) → two distinct addresses and pulses, no cross-contamination.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: selector-side bundle of the SPI target front end.
// master = spi_peripheral (address/data out, read data in); slave = selector.
interface spi_peripheral_if;
  logic [7:0] address_out;
  logic       address_out_valid;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [7:0] data_in;
  logic       data_in_valid;

  modport master (
    output address_out,
    output address_out_valid,
    output data_out,
    output data_out_valid,
    input  data_in,
    input  data_in_valid
  );

  modport slave (
    input  address_out,
    input  address_out_valid,
    input  data_out,
    input  data_out_valid,
    output data_in,
    output data_in_valid
  );
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI mode-0 target, byte 0 = address, then data.
// Ports: clock_in/reset_in, SPI pins (select/clock/data in, data out), bus.
module spi_peripheral #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_CIPO   = 1'b0
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic spi_select_in,
  input  logic spi_clock_in,
  input  logic spi_data_in,
  output logic spi_data_out,
  spi_peripheral_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDRESS,
    DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sel_q;
  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic                   sck_d;
  logic                   sel_s;
  logic                   sck_s;
  logic                   copi_s;
  logic                   rise;
  logic                   fall;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic [7:0] rx_q;
  logic [7:0] rx_d;
  logic [7:0] tx_q;
  logic       load_q;
  logic       addr_done;
  logic       data_done;
  logic       tx_shift;

  assign sel_s  = sel_q[SYNC_STAGES-1];
  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign copi_s = copi_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_d;
  assign fall   = ~sck_s & sck_d;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sel_q  <= '1;
      sck_q  <= '0;
      copi_q <= '0;
      sck_d  <= 1'b0;
    end else begin
      sel_q  <= {sel_q[SYNC_STAGES-2:0], spi_select_in};
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_clock_in};
      copi_q <= {copi_q[SYNC_STAGES-2:0], spi_data_in};
      sck_d  <= sck_s;
    end
  end

  // Deselect wins over any coincident SCLK edge, so a byte
  // finishing as select rises is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    addr_done = 1'b0;
    data_done = 1'b0;
    tx_shift  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (!sel_s) state_d = ADDRESS;
      end
      ADDRESS: begin
        if (sel_s) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (rise) begin
          rx_d  = {rx_q[6:0], copi_s};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            addr_done = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (sel_s) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (rise) begin
            rx_d  = {rx_q[6:0], copi_s};
            cnt_d = cnt_q + 3'd1;
            data_done = (cnt_q == 3'd7);
          end
          // cnt 0 marks the fall after a byte's last bit: the
          // freshly loaded MSB must stay on the line.
          if (fall && cnt_q != 3'd0) tx_shift = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q               <= IDLE;
      cnt_q                 <= 3'd0;
      rx_q                  <= 8'h00;
      tx_q                  <= 8'h00;
      load_q                <= 1'b0;
      bus.address_out       <= 8'h00;
      bus.address_out_valid <= 1'b0;
      bus.data_out          <= 8'h00;
      bus.data_out_valid    <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      rx_q               <= rx_d;
      load_q             <= addr_done | data_done;
      bus.data_out_valid <= data_done;
      if (addr_done) begin
        bus.address_out       <= rx_d;
        bus.address_out_valid <= 1'b1;
      end else if (sel_s) begin
        bus.address_out_valid <= 1'b0;
      end
      if (data_done) bus.data_out <= rx_d;
      // Load one cycle after the selector sees the completed byte.
      if (load_q) begin
        tx_q <= bus.data_in_valid ? bus.data_in : 8'h00;
      end else if (tx_shift) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
    end
  end

  assign spi_data_out = (state_q == DATA) ? tx_q[7] : IDLE_CIPO;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: randomized SPI transactions vs. a byte-level model.
// Checks address/data decode, CIPO read data, aborts, reset and gaps.
module tb_spi_peripheral;
  localparam int   SYNC = 2;
  localparam logic IDLE = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ssel = 1'b1;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic sdo;

  spi_peripheral_if bus ();

  spi_peripheral #(
    .SYNC_STAGES(SYNC),
    .IDLE_CIPO(IDLE)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .spi_select_in(ssel),
    .spi_clock_in(sclk),
    .spi_data_in(sdi),
    .spi_data_out(sdo),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_addr[$];
  logic [7:0] got_data[$];
  logic       prev_dv = 1'b0;
  logic       prev_av = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.data_out_valid) begin
      got_data.push_back(bus.data_out);
      check("pulse_width", {31'd0, prev_dv}, 32'd0);
    end
    if (bus.address_out_valid && !prev_av) got_addr.push_back(bus.address_out);
    prev_dv = bus.data_out_valid;
    prev_av = bus.address_out_valid;
  end

  logic [7:0] tb_byte[8];
  logic [7:0] tb_rsp[8];
  logic       tb_rspv[8];
  logic [7:0] rd[8];
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic cipo);
    sdi = b;
    tick(4);
    cipo = sdo;
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb,
                           output logic [7:0] r);
    logic c;
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_bit(b[7-i], c);
      r = {r[6:0], c};
    end
    tick(4);
  endtask

  // n complete bytes (byte 0 = address), then `partial` bits of
  // tb_byte[n], then deselect held for SYNC+2+gap cycles.
  task automatic txn(input int n, input int partial, input int gap);
    logic [7:0] r;
    int drop;
    got_addr.delete();
    got_data.delete();
    ssel = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      bus.data_in       = tb_rsp[i+1];
      bus.data_in_valid = tb_rspv[i+1];
      send_bits(tb_byte[i], 8, rd[i]);
    end
    if (partial > 0) send_bits(tb_byte[n], partial, r);
    ssel = 1'b1;
    drop = -1;
    for (int c = 1; c <= SYNC + 2; c++) begin
      tick(1);
      if (drop < 0 && !bus.address_out_valid) drop = c;
    end
    check("valid_drop", {31'd0, drop > 0}, 32'd1);
    tick(gap);
    if (n >= 1) last_addr = tb_byte[0];
    if (n >= 2) last_data = tb_byte[n-1];
    check("n_addr", got_addr.size(), (n >= 1) ? 1 : 0);
    if (n >= 1 && got_addr.size() >= 1) check("addr", got_addr[0], tb_byte[0]);
    check("addr_hold", bus.address_out, last_addr);
    check("data_hold", bus.data_out, last_data);
    check("n_data", got_data.size(), (n >= 1) ? n - 1 : 0);
    for (int k = 1; k < n; k++) begin
      if (k - 1 < got_data.size()) check("data", got_data[k-1], tb_byte[k]);
      check("cipo", rd[k], tb_rspv[k] ? tb_rsp[k] : 8'h00);
    end
    if (n >= 1) check("cipo_addr", rd[0], {8{IDLE}});
    check("cipo_idle", sdo, IDLE);
  endtask

  task automatic set_txn(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] r1,
                         input logic [7:0] r2, input logic v);
    tb_byte[0] = b0; tb_byte[1] = b1; tb_byte[2] = b2;
    tb_rsp[1] = r1; tb_rsp[2] = r2; tb_rsp[3] = 8'h00;
    tb_rspv[1] = v; tb_rspv[2] = v; tb_rspv[3] = v;
  endtask

  initial begin
    logic [7:0] r;
    bus.data_in = 8'h00;
    bus.data_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tb_byte[i] = 8'h00; tb_rsp[i] = 8'h00; tb_rspv[i] = 1'b0; rd[i] = 8'h00;
    end
    tick(3);
    check("rst_addr", bus.address_out, 8'h00);
    check("rst_av", bus.address_out_valid, 1'b0);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_dv", bus.data_out_valid, 1'b0);
    check("rst_cipo", sdo, IDLE);
    rst = 1'b0;
    tick(4);

    set_txn(8'hA0, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1);
    txn(3, 0, 4);
    set_txn(8'hB5, 8'h00, 8'h00, 8'h5A, 8'hC3, 1'b1);
    txn(3, 0, 4);
    set_txn(8'hB5, 8'hFF, 8'h00, 8'h99, 8'h00, 1'b0);
    txn(2, 0, 4);
    set_txn(8'hA0, 8'hE7, 8'h00, 8'h00, 8'h00, 1'b0);
    txn(1, 5, 4);
    set_txn(8'hB5, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0);
    txn(2, 0, 4);

    got_addr.delete();
    got_data.delete();
    ssel = 1'b0;
    tick(6);
    ssel = 1'b1;
    tick(6);
    check("zclk_addr", got_addr.size(), 0);
    check("zclk_data", got_data.size(), 0);
    check("zclk_hold", bus.data_out, last_data);

    ssel = 1'b0;
    tick(4);
    send_bits(8'hA0, 8, r);
    send_bits(8'hFF, 4, r);
    rst = 1'b1;
    tick(1);
    check("mid_addr", bus.address_out, 8'h00);
    check("mid_av", bus.address_out_valid, 1'b0);
    check("mid_data", bus.data_out, 8'h00);
    check("mid_dv", bus.data_out_valid, 1'b0);
    check("mid_cipo", sdo, IDLE);
    rst = 1'b0;
    ssel = 1'b1;
    tick(6);
    last_addr = 8'h00;
    last_data = 8'h00;
    set_txn(8'hC1, 8'h3C, 8'h00, 8'hA5, 8'h00, 1'b1);
    txn(2, 0, 4);

    set_txn(8'hA0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    txn(2, 0, 0);
    set_txn(8'hB5, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0);
    txn(2, 0, 4);

    for (int t = 0; t < 20; t++) begin
      int n;
      int p;
      n = $urandom_range(0, 4);
      p = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 8; i++) begin
        tb_byte[i] = 8'($urandom);
        tb_rsp[i]  = 8'($urandom);
        tb_rspv[i] = 1'($urandom);
      end
      txn(n, p, $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
